// File: rtl/prog_pkg.sv
// Shared types and helpers for the picoMIPS writable program-memory loader.
package prog_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;

    // Bits of the high byte that carry instruction data; anything outside is a format error.
    function automatic logic [7:0] hi_byte_mask(input int isize);
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < isize - 8) m[b] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: synchronous write port, combinational read port that returns zero past Nwords.
module prog_ram #(
    parameter int Psize  = 5,
    parameter int Isize  = 15,
    parameter int Nwords = 22
) (
    input  logic             clk,
    input  logic             we,
    input  logic [Psize-1:0] wa,
    input  logic [Isize-1:0] wd,
    input  logic [Psize-1:0] ra,
    output logic [Isize-1:0] rd
);

    localparam logic [Psize:0] NW = (Psize + 1)'(Nwords);

    logic [Isize-1:0] r_mem [Nwords];
    logic             w_rd_in_range;

    // Deliberately no reset: stale words survive reset and restarts.
    always_ff @(posedge clk) begin
        if (we) r_mem[wa] <= wd;
    end

    assign w_rd_in_range = ({1'b0, ra} < NW);
    assign rd            = w_rd_in_range ? r_mem[ra] : '0;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian byte pairs into instructions,
// fills the program RAM from address 0 and holds the CPU until the load completes.
module prog_loader
    import prog_pkg::*;
#(
    parameter int Psize  = 5,
    parameter int Isize  = 15,
    parameter int Nwords = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Psize-1:0] address,
    output logic [Isize-1:0] I,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             fmt_err,
    output logic [2:0]       dbg_state
);

    // Handshake: a byte moves on the rising edge where in_valid && in_ready are both high;
    // in_ready is registered and high only in LO/HI, so the source may hold in_valid freely.

    localparam int               HI_W      = Isize - 8 * (BYTES_PER_WORD - 1);
    localparam logic [7:0]       HI_MASK   = hi_byte_mask(Isize);
    localparam logic [Psize-1:0] LAST_ADDR = Psize'(Nwords - 1);

    loader_state_t    r_state;
    logic [Psize-1:0] r_wr_addr;
    logic [7:0]       r_lo;
    logic [HI_W-1:0]  r_hi;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_cpu_hold;
    logic             r_fmt_err;

    logic             w_we;
    logic [Isize-1:0] w_wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_addr  <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_fmt_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= LO;
                        r_wr_addr  <= '0;
                        r_fmt_err  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                LO: begin
                    if (in_valid && r_in_ready) begin
                        r_lo    <= in_data;
                        r_state <= HI;
                    end
                end
                HI: begin
                    if (in_valid && r_in_ready) begin
                        r_hi       <= in_data[HI_W-1:0];
                        r_state    <= WR;
                        r_in_ready <= 1'b0;
                        if (|(in_data & ~HI_MASK)) r_fmt_err <= 1'b1;
                    end
                end
                WR: begin
                    if (r_wr_addr == LAST_ADDR) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_wr_addr  <= r_wr_addr + 1'b1;
                        r_state    <= LO;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign w_we = (r_state == WR);
    assign w_wd = {r_hi, r_lo};

    prog_ram #(
        .Psize  (Psize),
        .Isize  (Isize),
        .Nwords (Nwords)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .wa  (r_wr_addr),
        .wd  (w_wd),
        .ra  (address),
        .rd  (I)
    );

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cpu_hold  = r_cpu_hold;
    assign fmt_err   = r_fmt_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;
    import prog_pkg::*;

    localparam int PSIZE  = 5;
    localparam int ISIZE  = 15;
    localparam int NWORDS = 22;
    localparam int NBYTES = 44;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [PSIZE-1:0] address;
    logic [ISIZE-1:0] I;
    logic             busy;
    logic             done;
    logic             cpu_hold;
    logic             fmt_err;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       stream [NBYTES];
    logic [ISIZE-1:0] exp_q [$];
    int               hs_count;
    int               done_cyc;

    prog_loader #(.Psize(PSIZE), .Isize(ISIZE), .Nwords(NWORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .address   (address),
        .I         (I),
        .busy      (busy),
        .done      (done),
        .cpu_hold  (cpu_hold),
        .fmt_err   (fmt_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    function automatic logic [ISIZE-1:0] std_word(input int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(k);
        hi = 8'(k + 16);
        return {hi[6:0], lo};
    endfunction

    function automatic logic [ISIZE-1:0] alt_word(input int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(k) ^ 8'hA5;
        hi = 8'(k + 64);
        return {hi[6:0], lo};
    endfunction

    task automatic build_stream(input bit alt);
        logic [ISIZE-1:0] w;
        exp_q.delete();
        for (int k = 0; k < NWORDS; k++) begin
            w = alt ? alt_word(k) : std_word(k);
            stream[2*k]   = w[7:0];
            stream[2*k+1] = {1'b0, w[14:8]};
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Drives bytes [first, nbytes) with optional random gaps; cycle 1 is the cycle after the start edge.
    task automatic send_stream(input int first, input int nbytes, input int gap_pct,
                               input int start_idx, input int start_cyc, input bit wait_done);
        int idx;
        int cyc;
        bit hs;
        idx      = first;
        cyc      = 1;
        hs_count = 0;
        done_cyc = -1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (wait_done && done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (!wait_done && idx == nbytes) break;
            in_data  = (idx < nbytes) ? stream[idx] : 8'h00;
            in_valid = (idx < nbytes) && ($urandom_range(99) >= gap_pct);
            start    = ((idx == start_idx) && (idx < nbytes)) || (cyc == start_cyc);
            hs       = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            if (hs) begin
                idx++;
                hs_count++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        address  = '0;
        #2;
        n_checks++;
        if ({cpu_hold, done, in_ready, busy, fmt_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got hold/done/rdy/busy/err=%b, want 10000",
                     {cpu_hold, done, in_ready, busy, fmt_err});
        end
        n_checks++;
        if (dbg_state !== 3'(IDLE)) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, want %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg_state !== 3'(IDLE) || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_consume: got state=%0d rdy=%b busy=%b, want 0/0/0",
                     dbg_state, in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_rate();
        build_stream(1'b0);
        pulse_start();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || dbg_state !== 3'(LO)) begin
            n_fail++;
            $display("FAIL start_to_lo: got rdy=%b busy=%b state=%0d, want 1/1/%0d",
                     in_ready, busy, dbg_state, LO);
        end
        send_stream(0, NBYTES, 0, -1, -1, 1'b1);
        n_checks++;
        if (done_cyc != 67) begin
            n_fail++;
            $display("FAIL full_rate_done_cycle: got %0d, want 67", done_cyc);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flags: got hold=%b busy=%b rdy=%b, want 0/0/0", cpu_hold, busy, in_ready);
        end
        address = 5'd5;
        #1;
        n_checks++;
        if (I !== 15'h1505) begin
            n_fail++;
            $display("FAIL read_addr5: got %h, want 1505", I);
        end
        address = 5'd22;
        #1;
        n_checks++;
        if (I !== 15'h0000) begin
            n_fail++;
            $display("FAIL read_addr22: got %h, want 0000", I);
        end
        address = 5'd31;
        #1;
        n_checks++;
        if (I !== 15'h0000) begin
            n_fail++;
            $display("FAIL read_addr31: got %h, want 0000", I);
        end
        for (int a = 0; a < NWORDS; a++) begin
            address = 5'(a);
            #1;
            n_checks++;
            if (I !== exp_q[a]) begin
                n_fail++;
                $display("FAIL full_rate_mem[%0d]: got %h, want %h", a, I, exp_q[a]);
            end
        end
    endtask

    task automatic test_fmt_err();
        build_stream(1'b0);
        stream[7] = 8'h80;
        exp_q[3]  = 15'h0003;
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done_drop: got done=%b busy=%b, want 0/1", done, busy);
        end
        send_stream(0, 7, 0, -1, -1, 1'b0);
        n_checks++;
        if (fmt_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fmt_err_before: got %b, want 0", fmt_err);
        end
        send_stream(7, 8, 0, -1, -1, 1'b0);
        n_checks++;
        if (fmt_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fmt_err_set: got %b, want 1", fmt_err);
        end
        send_stream(8, NBYTES, 0, -1, -1, 1'b1);
        n_checks++;
        if (done !== 1'b1 || fmt_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fmt_err_sticky: got done=%b err=%b, want 1/1", done, fmt_err);
        end
        address = 5'd3;
        #1;
        n_checks++;
        if (I !== 15'h0003) begin
            n_fail++;
            $display("FAIL fmt_mem3: got %h, want 0003", I);
        end
        address = 5'd4;
        #1;
        n_checks++;
        if (I !== 15'h1404) begin
            n_fail++;
            $display("FAIL fmt_mem4: got %h, want 1404", I);
        end
    endtask

    task automatic test_random_gaps();
        build_stream(1'b0);
        pulse_start();
        n_checks++;
        if (fmt_err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got err=%b done=%b rdy=%b, want 0/0/1", fmt_err, done, in_ready);
        end
        send_stream(0, NBYTES, 35, -1, -1, 1'b1);
        n_checks++;
        if (done_cyc < 67 || hs_count != NBYTES) begin
            n_fail++;
            $display("FAIL gaps_handshakes: got done_cyc=%0d bytes=%0d, want >=67 and 44", done_cyc, hs_count);
        end
        for (int a = 0; a < NWORDS; a++) begin
            address = 5'(a);
            #1;
            n_checks++;
            if (I !== exp_q[a]) begin
                n_fail++;
                $display("FAIL gaps_mem[%0d]: got %h, want %h", a, I, exp_q[a]);
            end
        end
    endtask

    task automatic test_mid_reset();
        build_stream(1'b1);
        pulse_start();
        send_stream(0, 20, 0, -1, -1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (dbg_state !== 3'(IDLE) || cpu_hold !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d hold=%b busy=%b rdy=%b, want %0d/1/0/0",
                     dbg_state, cpu_hold, busy, in_ready, IDLE);
        end
        for (int a = 0; a < NWORDS; a++) begin
            address = 5'(a);
            #1;
            n_checks++;
            if (I !== ((a < 10) ? alt_word(a) : std_word(a))) begin
                n_fail++;
                $display("FAIL reset_retain_mem[%0d]: got %h, want %h", a, I,
                         (a < 10) ? alt_word(a) : std_word(a));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        build_stream(1'b0);
        pulse_start();
        send_stream(0, NBYTES, 0, -1, -1, 1'b1);
        n_checks++;
        if (done_cyc != 67) begin
            n_fail++;
            $display("FAIL reload_done_cycle: got %0d, want 67", done_cyc);
        end
        for (int a = 0; a < NWORDS; a++) begin
            address = 5'(a);
            #1;
            n_checks++;
            if (I !== exp_q[a]) begin
                n_fail++;
                $display("FAIL reload_mem[%0d]: got %h, want %h", a, I, exp_q[a]);
            end
        end
    endtask

    task automatic test_start_ignored();
        build_stream(1'b1);
        pulse_start();
        send_stream(0, NBYTES, 0, 9, 66, 1'b1);
        n_checks++;
        if (done_cyc != 67) begin
            n_fail++;
            $display("FAIL start_ignored_done_cycle: got %0d, want 67", done_cyc);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'(DONE)) begin
            n_fail++;
            $display("FAIL start_at_last_wr: got done=%b busy=%b state=%0d, want 1/0/%0d",
                     done, busy, dbg_state, DONE);
        end
        for (int a = 0; a < NWORDS; a++) begin
            address = 5'(a);
            #1;
            n_checks++;
            if (I !== exp_q[a]) begin
                n_fail++;
                $display("FAIL start_ignored_mem[%0d]: got %h, want %h", a, I, exp_q[a]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_rate();
        test_fmt_err();
        test_random_gaps();
        test_mid_reset();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
